// File: rtl/anspwm_pkg.sv
// rtl/anspwm_pkg.sv - shared types and default widths for the setpoint ramp path
package anspwm_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STEP_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    SETTLE    = 2'd3
  } ramp_state_e;

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - counts HOLD_TICKS ticks after start drops
module settle_timer #(
  parameter int HOLD_TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic tick,
  output logic expired
);

  localparam int CW = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);

  logic [CW-1:0] count;

  // start is held while the owner is outside SETTLE, so the count is reloaded until the hold begins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start) begin
      count <= CW'(HOLD_TICKS);
    end else if (tick && count != '0) begin
      count <= count - CW'(1);
    end
  end

  // Asserted on the edge that samples the last tick, or immediately when no hold is needed
  assign expired = (count == '0) || (tick && count == CW'(1));

endmodule

// File: rtl/target_ramp.sv
// rtl/target_ramp.sv - slews the DSP setpoint toward a requested goal in clamped per-tick steps
module target_ramp
  import anspwm_pkg::*;
#(
  parameter int               WIDTH        = DEFAULT_WIDTH,
  parameter int               STEP_W       = DEFAULT_STEP_W,
  parameter int               HOLD_TICKS   = 4,
  parameter logic [WIDTH-1:0] RESET_TARGET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              req_valid,
  input  logic [WIDTH-1:0]  req_target,
  input  logic [STEP_W-1:0] req_step,
  output logic              req_ready,
  input  logic              abort,
  output logic [WIDTH-1:0]  target,
  output logic              busy,
  output logic              done
);

  ramp_state_e       state;
  logic [WIDTH-1:0]  goal;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  step_ext;
  logic [WIDTH-1:0]  up_gap;
  logic [WIDTH-1:0]  down_gap;
  logic              settle_start;
  logic              settle_done;

  assign step_ext     = WIDTH'(step);
  assign up_gap       = goal - target;
  assign down_gap     = target - goal;
  assign req_ready    = (state == IDLE);
  assign settle_start = (state != SETTLE);

  settle_timer #(
    .HOLD_TICKS(HOLD_TICKS)
  ) u_settle (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (settle_start),
    .tick    (tick),
    .expired (settle_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      target <= RESET_TARGET;
      goal   <= RESET_TARGET;
      step   <= STEP_W'(1);
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            goal <= req_target;
            step <= (req_step == '0) ? STEP_W'(1) : req_step;
            if (req_target > target) begin
              state <= RAMP_UP;
              busy  <= 1'b1;
            end else if (req_target < target) begin
              state <= RAMP_DOWN;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RAMP_UP: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tick) begin
            // Gap compare before the add keeps the sum below goal, so it cannot wrap
            if (up_gap <= step_ext) begin
              target <= goal;
              state  <= SETTLE;
            end else begin
              target <= target + step_ext;
            end
          end
        end
        RAMP_DOWN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tick) begin
            if (down_gap <= step_ext) begin
              target <= goal;
              state  <= SETTLE;
            end else begin
              target <= target - step_ext;
            end
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (settle_done) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_target_ramp.sv
// tb/tb_target_ramp.sv - directed self-checking bench for target_ramp
module tb_target_ramp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic        req_valid;
  logic        req_valid2;
  logic [31:0] req_target;
  logic [15:0] req_step;
  logic        abort;
  logic        req_ready, busy, done;
  logic [31:0] target;
  logic        req_ready2, busy2, done2;
  logic [31:0] target2;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  target_ramp u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .req_valid  (req_valid),
    .req_target (req_target),
    .req_step   (req_step),
    .req_ready  (req_ready),
    .abort      (abort),
    .target     (target),
    .busy       (busy),
    .done       (done)
  );

  // Second instance parked near the top of the range with no settle hold
  target_ramp #(
    .HOLD_TICKS   (0),
    .RESET_TARGET (32'hFFFD_0000)
  ) u_hi (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .req_valid  (req_valid2),
    .req_target (req_target),
    .req_step   (req_step),
    .req_ready  (req_ready2),
    .abort      (abort),
    .target     (target2),
    .busy       (busy2),
    .done       (done2)
  );

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick;
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic send(input logic [31:0] t, input logic [15:0] s);
    req_target = t;
    req_step   = s;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  task automatic send2(input logic [31:0] t, input logic [15:0] s);
    req_target = t;
    req_step   = s;
    req_valid2 = 1'b1;
    @(negedge clk);
    req_valid2 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cyc(2);
    n_checks++; if (target !== 32'd0) begin n_fail++; $display("FAIL reset_target got %0d exp 0", target); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    n_checks++; if (target2 !== 32'hFFFD_0000) begin n_fail++; $display("FAIL reset_target_hi got %h exp fffd0000", target2); end
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_ramp_up;
    logic [31:0] exp_seq [4] = '{32'd30, 32'd60, 32'd90, 32'd100};
    int base;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL up_ready got %b exp 1", req_ready); end
    send(100, 30);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL up_busy got %b exp 1", busy); end
    n_checks++; if (target !== 32'd0) begin n_fail++; $display("FAIL up_no_early_step got %0d exp 0", target); end
    for (int i = 0; i < 4; i++) begin
      do_tick;
      n_checks++; if (target !== exp_seq[i]) begin n_fail++; $display("FAIL up_step%0d got %0d exp %0d", i, target, exp_seq[i]); end
      if (i == 0) begin
        req_target = 32'd5;
        req_valid  = 1'b1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL up_ready_busy got %b exp 0", req_ready); end
        @(negedge clk);
        req_valid  = 1'b0;
      end
    end
    base = done_cnt;
    for (int i = 0; i < 3; i++) begin
      do_tick;
      n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL up_hold%0d got done=%b busy=%b exp done=0 busy=1", i, done, busy); end
    end
    do_tick;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL up_done got %b exp 1", done); end
    n_checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL up_idle got busy=%b ready=%b exp 0/1", busy, req_ready); end
    cyc(1);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL up_done_pulse got %b exp 0", done); end
    n_checks++; if (done_cnt !== base + 1) begin n_fail++; $display("FAIL up_done_count got %0d exp %0d", done_cnt, base + 1); end
  endtask

  task automatic test_ramp_down;
    int base = done_cnt;
    send(10, 50);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL down_busy got %b exp 1", busy); end
    do_tick;
    n_checks++; if (target !== 32'd50) begin n_fail++; $display("FAIL down_step0 got %0d exp 50", target); end
    do_tick;
    n_checks++; if (target !== 32'd10) begin n_fail++; $display("FAIL down_clamp got %0d exp 10", target); end
    repeat (4) do_tick;
    cyc(1);
    n_checks++; if (target !== 32'd10 || busy !== 1'b0) begin n_fail++; $display("FAIL down_end got target=%0d busy=%b exp 10/0", target, busy); end
    n_checks++; if (done_cnt !== base + 1) begin n_fail++; $display("FAIL down_done_count got %0d exp %0d", done_cnt, base + 1); end
  endtask

  task automatic test_top_clamp;
    logic [31:0] exp_seq [3] = '{32'hFFFD_FFFF, 32'hFFFE_FFFE, 32'hFFFF_FFF0};
    send2(32'hFFFF_FFF0, 16'hFFFF);
    n_checks++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL top_busy got %b exp 1", busy2); end
    for (int i = 0; i < 3; i++) begin
      do_tick;
      n_checks++; if (target2 !== exp_seq[i]) begin n_fail++; $display("FAIL top_step%0d got %h exp %h", i, target2, exp_seq[i]); end
    end
    n_checks++; if (done2 !== 1'b0 || busy2 !== 1'b1) begin n_fail++; $display("FAIL top_settle got done=%b busy=%b exp 0/1", done2, busy2); end
    cyc(1);
    n_checks++; if (done2 !== 1'b1 || busy2 !== 1'b0) begin n_fail++; $display("FAIL top_hold0_done got done=%b busy=%b exp 1/0", done2, busy2); end
    cyc(1);
    n_checks++; if (done2 !== 1'b0 || target2 !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL top_final got done=%b target=%h exp 0/fffffff0", done2, target2); end
    n_checks++; if (target !== 32'd10) begin n_fail++; $display("FAIL idle_ticks_target got %0d exp 10", target); end
  endtask

  task automatic test_step_zero;
    int base = done_cnt;
    tick = 1'b1;
    send(500, 0);
    tick = 1'b0;
    n_checks++; if (target !== 32'd10) begin n_fail++; $display("FAIL zero_transfer_tick got %0d exp 10", target); end
    for (int k = 1; k <= 3; k++) begin
      do_tick;
      n_checks++; if (target !== 32'(10 + k)) begin n_fail++; $display("FAIL zero_step%0d got %0d exp %0d", k, target, 10 + k); end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || target !== 32'd13) begin n_fail++; $display("FAIL zero_abort got busy=%b ready=%b target=%0d exp 0/1/13", busy, req_ready, target); end
    cyc(2);
    n_checks++; if (done_cnt !== base) begin n_fail++; $display("FAIL zero_abort_done got %0d exp %0d", done_cnt, base); end
  endtask

  task automatic test_abort;
    int base;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    base = done_cnt;
    send(100, 30);
    do_tick;
    do_tick;
    n_checks++; if (target !== 32'd60) begin n_fail++; $display("FAIL abort_pre got %0d exp 60", target); end
    tick  = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    tick  = 1'b0;
    abort = 1'b0;
    n_checks++; if (target !== 32'd60 || busy !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_tick got target=%0d busy=%b ready=%b exp 60/0/1", target, busy, req_ready); end
    cyc(3);
    n_checks++; if (target !== 32'd60 || done_cnt !== base) begin n_fail++; $display("FAIL abort_frozen got target=%0d dones=%0d exp 60/%0d", target, done_cnt, base); end
    send(90, 30);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_new_req got busy=%b exp 1", busy); end
    do_tick;
    n_checks++; if (target !== 32'd90) begin n_fail++; $display("FAIL abort_new_ramp got %0d exp 90", target); end
    abort = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || target !== 32'd90) begin n_fail++; $display("FAIL abort_settle got busy=%b target=%0d exp 0/90", busy, target); end
    send(120, 30);
    abort = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_idle_req got busy=%b exp 1", busy); end
    do_tick;
    n_checks++; if (target !== 32'd120) begin n_fail++; $display("FAIL abort_idle_ramp got %0d exp 120", target); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cyc(2);
    n_checks++; if (done_cnt !== base) begin n_fail++; $display("FAIL abort_no_done got %0d exp %0d", done_cnt, base); end
  endtask

  task automatic test_equal_and_reset;
    int base = done_cnt;
    send(120, 7);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL equal_done got done=%b busy=%b exp 1/0", done, busy); end
    cyc(1);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL equal_after got done=%b busy=%b exp 0/0", done, busy); end
    n_checks++; if (done_cnt !== base + 1) begin n_fail++; $display("FAIL equal_count got %0d exp %0d", done_cnt, base + 1); end
    send(200, 30);
    do_tick;
    n_checks++; if (target !== 32'd150) begin n_fail++; $display("FAIL rst_pre got %0d exp 150", target); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (target !== 32'd0 || busy !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async got target=%0d busy=%b ready=%b exp 0/0/1", target, busy, req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    n_checks++; if (done_cnt !== base + 1 || target !== 32'd0) begin n_fail++; $display("FAIL rst_no_done got dones=%0d target=%0d exp %0d/0", done_cnt, target, base + 1); end
  endtask

  initial begin
    tick       = 1'b0;
    req_valid  = 1'b0;
    req_valid2 = 1'b0;
    req_target = '0;
    req_step   = '0;
    abort      = 1'b0;
    test_reset;
    test_ramp_up;
    test_ramp_down;
    test_top_clamp;
    test_step_zero;
    test_abort;
    test_equal_and_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
